peribus_master: RTL
===================

// Module: peribus_master
// PURPOSE
//  Peribus initiator: converts CPU load/store requests into Peribus cycles for up to N_PERIPH
//  responders (timer, GPIO, UART, ...). Decodes the address window, drives one chipselect,
//  shared addr/write_data/strobes, captures the responder's registered read_data and returns
//  it on a valid/ready response channel. Sits between the CPU's memory stage and the peripherals.
// PARAMETERS
//  N_PERIPH   4        responders; power of two, 1..16; each owns 4 words
//  BASE_ADDR  16'hFF00 word address of responder 0, register 0
// PORTS
//  clock        in   1             system clock, all logic on posedge
//  reset        in   1             asynchronous, active-high reset
//  req_valid    in   1             CPU request valid
//  req_ready    out  1             block can accept a request
//  req_write    in   1             1 = store, 0 = load
//  req_addr     in   16            CPU word address
//  req_wdata    in   16            store data
//  resp_valid   out  1             response valid; held until resp_ready
//  resp_ready   in   1             CPU accepts response
//  resp_rdata   out  16            load data; 0 for stores and errors
//  resp_err     out  1             address outside the decoded window
//  addr         out  2             Peribus register select
//  write_data   out  16            Peribus write data
//  write_en     out  1             Peribus write strobe
//  read_en      out  1             Peribus read strobe
//  chipselect   out  N_PERIPH      one-hot responder select
//  read_data    in   16*N_PERIPH   responder i read data at [16*i +: 16]
//  irq_in       in   N_PERIPH      responder irq lines
//  irq_out      out  1             aggregated interrupt to CPU
// BEHAVIOUR
//  - Reset: all outputs 0, except req_ready = 1. State IDLE. Takes effect mid-cycle.
//    Strobes and chipselect drop immediately, even during ISSUE. An in-flight request is
//    discarded and no response is returned.
//  - Decode: off = {1'b0,req_addr} - {1'b0,BASE_ADDR}, computed 17 bits wide.
//    The address is in window iff no borrow and off < 4*N_PERIPH.
//    idx = off >> 2; addr = off[1:0].
//  - States:
//    - IDLE: req_ready = 1. On req_valid, latch write, addr, wdata and idx. Go to ISSUE if in
//      window, else ERR. req_ready is 0 in every other state.
//    - ISSUE: exactly 1 cycle. chipselect[idx] = 1, addr, write_data, and write_en (store) or
//      read_en (load). All are registered outputs and are 0 in every other state.
//      A store goes to RESP; a load goes to CAPTURE.
//    - CAPTURE: 1 cycle. The responder registered read_data on the ISSUE edge.
//      resp_rdata <= read_data[16*idx +: 16]. Go to RESP.
//    - ERR: resp_err <= 1, resp_rdata <= 0, no Peribus activity. Go to RESP.
//    - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. When resp_ready = 1, go
//      to IDLE and clear resp_valid and resp_err.
//  - Latency, accept edge to first resp_valid cycle: store 2, load 3, error 2 cycles.
//    Throughput is at most one request per 3 (store) or 4 (load) cycles, with no overlap.
//  - resp_ready low: stay in RESP indefinitely. A new req_valid is ignored (req_ready = 0).
//  - A request is accepted in the same cycle as a response completes only via IDLE, i.e. one
//    cycle later.
//  - Any change on req_* after acceptance has no effect.
//  - Exactly one chipselect bit is high, for exactly one cycle per in-window request.
//    A strobe is never asserted without a chipselect bit.
// CONFIGURATION
//  PERIBUS_IRQ_AGG_EN defined:
//  - The window grows by 4 words: off in [4*N_PERIPH, 4*N_PERIPH+3] hits internal registers
//    and issues no Peribus cycle. Internal accesses follow the ISSUE/CAPTURE timing with
//    chipselect = 0.
//  - Internal reg 0: irq_mask (N_PERIPH bits, R/W, reset 0).
//  - Internal reg 1: irq_in raw (read-only; writes ignored).
//  - Internal regs 2-3: read 0.
//  - irq_out = registered |(irq_in & irq_mask); one cycle latency.
//  PERIBUS_IRQ_AGG_EN undefined:
//  - The window is 4*N_PERIPH words only; the extra words give resp_err.
//  - irq_in is ignored and irq_out = 0.
// TESTING
//  - Store FF05 = 16'h1234 (N_PERIPH=4) -> one ISSUE cycle with chipselect = 4'b0010, addr = 1,
//    write_en = 1, write_data = 16'h1234. resp_valid 2 cycles after accept, resp_err = 0.
//  - Load FF0E with responder 3 returning 16'hBEEF on the edge after read_en ->
//    chipselect = 4'b1000, addr = 2, resp_rdata = 16'hBEEF 3 cycles after accept.
//  - Load FEFF, then load FF10 -> no chipselect or strobes, resp_err = 1, resp_rdata = 0.
//    FF10 is in window only with PERIBUS_IRQ_AGG_EN.
//  - resp_ready held 0 for 10 cycles with req_valid = 1 -> resp_valid stays 1, data stable,
//    req_ready = 0. Release -> IDLE, next request accepted.
//  - Assert reset during ISSUE -> chipselect and strobes 0 immediately. After release:
//    req_ready = 1, resp_valid = 0.
//  - With PERIBUS_IRQ_AGG_EN: store FF10 = 4'b0100, irq_in = 4'b0110 -> irq_out = 1 next
//    cycle. Load FF11 -> resp_rdata = 16'h0006.

Source files
------------

// File: rtl/peribus_master.sv
// Peribus initiator: turns CPU load/store requests into single-cycle Peribus
// accesses over a one-hot chipselect, and returns the result on a valid/ready
// response channel.
// Optional feature: define PERIBUS_IRQ_AGG_EN to add four internal registers
// (irq mask, raw irq) after the responder window and a registered irq_out.
module peribus_master #(
    parameter int          N_PERIPH  = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [15:0]           req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            addr,
    output logic [15:0]           write_data,
    output logic                  write_en,
    output logic                  read_en,
    output logic [N_PERIPH-1:0]   chipselect,
    input  logic [16*N_PERIPH-1:0] read_data,
    input  logic [N_PERIPH-1:0]   irq_in,
    output logic                  irq_out
);

    localparam int          IW  = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
    localparam int unsigned WIN = 4 * N_PERIPH;
`ifdef PERIBUS_IRQ_AGG_EN
    localparam int unsigned WIN_TOP = WIN + 4;
`else
    localparam int unsigned WIN_TOP = WIN;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_ERR,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d;
    logic                  int_q, int_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [1:0]            reg_q, reg_d;
    logic [15:0]           wdata_q, wdata_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [15:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [1:0]            addr_q, addr_d;
    logic [15:0]           write_data_q, write_data_d;
    logic                  write_en_q, write_en_d;
    logic                  read_en_q, read_en_d;
    logic [N_PERIPH-1:0]   chipselect_q, chipselect_d;
    logic                  irq_out_q, irq_out_d;
    logic [N_PERIPH-1:0]   mask_q, mask_d;

    logic [16:0]           off;
    logic                  in_win;
    logic                  is_int;
    logic [15:0]           sel_rdata;
    logic [15:0]           int_rdata;

    // Address decode: 17-bit subtraction so a borrow flags addresses below the window
    always_comb begin
        off    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        in_win = !off[16] && (off[15:0] < 16'(WIN_TOP));
`ifdef PERIBUS_IRQ_AGG_EN
        is_int = in_win && (off[15:0] >= 16'(WIN));
`else
        is_int = 1'b0;
`endif
    end

    // Responder read data mux and internal register read mux
    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_PERIPH; i++) begin
            if (idx_q == IW'(i)) begin
                sel_rdata = read_data[16*i +: 16];
            end
        end
        int_rdata = '0;
`ifdef PERIBUS_IRQ_AGG_EN
        case (reg_q)
            2'd0:    int_rdata = 16'(mask_q);
            2'd1:    int_rdata = 16'(irq_in);
            default: int_rdata = '0;
        endcase
`endif
    end

`ifndef PERIBUS_IRQ_AGG_EN
    logic unused_irq;
    assign unused_irq = ^{irq_in, int_rdata};
`endif

    // Next-state logic; Peribus and handshake outputs are derived from the next state
    // so that they are registered and line up exactly with the state they belong to
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        int_d        = int_q;
        idx_d        = idx_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mask_d       = mask_q;
        irq_out_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    idx_d   = off[2 +: IW];
                    reg_d   = off[1:0];
                    int_d   = is_int;
                    state_d = in_win ? S_ISSUE : S_ERR;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    resp_rdata_d = '0;
                    state_d      = S_RESP;
                end else begin
                    state_d      = S_CAPTURE;
                end
`ifdef PERIBUS_IRQ_AGG_EN
                if (int_q && wr_q && (reg_q == 2'd0)) begin
                    mask_d = wdata_q[N_PERIPH-1:0];
                end
`endif
            end
            S_CAPTURE: begin
                resp_rdata_d = int_q ? int_rdata : sel_rdata;
                state_d      = S_RESP;
            end
            S_ERR: begin
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PERIBUS_IRQ_AGG_EN
        irq_out_d = |(irq_in & mask_q);
`endif

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);

        chipselect_d = '0;
        addr_d       = '0;
        write_data_d = '0;
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        if ((state_d == S_ISSUE) && !int_d) begin
            for (int unsigned i = 0; i < N_PERIPH; i++) begin
                if (idx_d == IW'(i)) begin
                    chipselect_d[i] = 1'b1;
                end
            end
            addr_d       = reg_d;
            write_data_d = wdata_d;
            write_en_d   = wr_d;
            read_en_d    = !wr_d;
        end
    end

    // State and registered outputs; reset drops every strobe at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            int_q        <= 1'b0;
            idx_q        <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            chipselect_q <= '0;
            irq_out_q    <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            int_q        <= int_d;
            idx_q        <= idx_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            addr_q       <= addr_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            chipselect_q <= chipselect_d;
            irq_out_q    <= irq_out_d;
            mask_q       <= mask_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign addr       = addr_q;
    assign write_data = write_data_q;
    assign write_en   = write_en_q;
    assign read_en    = read_en_q;
    assign chipselect = chipselect_q;
    assign irq_out    = irq_out_q;

endmodule
